axi_mem_arbiter: RTL and testbench
==================================

AXI_MEM_ARBITER -- requirements
Module: axi_mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 64, meaning AXI address width.
REQ-002 SHALL have parameter DATA_W, default 64, meaning AXI beat width.
REQ-003 SHALL have parameter BEATS, default 8, meaning beats per burst (one 512-bit line).
REQ-004 SHALL have ports, one per line below; prefix sN_ means one port each for s0_ and s1_.
- clk  input  1  clock.
- reset  input  1  reset, synchronous, active-high.
- sN_axi_araddr / sN_axi_arvalid  input  ADDR_W / 1  requester read address and valid.
- sN_axi_arready  output  1  read address accepted.
- sN_axi_rdata / sN_axi_rlast / sN_axi_rvalid  output  DATA_W / 1 / 1  routed read beat.
- sN_axi_rready  input  1  requester read-beat ready.
- sN_axi_awaddr / sN_axi_awvalid  input  ADDR_W / 1  requester write address and valid.
- sN_axi_awready  output  1  write address accepted.
- sN_axi_wdata / sN_axi_wlast / sN_axi_wvalid  input  DATA_W / 1 / 1  requester write beat.
- sN_axi_wready  output  1  write beat accepted.
- sN_axi_bvalid  output  1  routed write response.
- sN_axi_bready  input  1  requester response ready.
- m_axi_*  mirrored set (araddr, arvalid, arready, rdata, rlast, rvalid, rready, awaddr, awvalid, awready, wdata, wlast, wvalid, wready, bvalid, bready)  opposite direction  memory-side port.
- rd_len_err / wr_len_err  output  1  one-cycle pulse on a burst-length mismatch.

Function
REQ-005 Read and write paths SHALL be independent FSMs; they may serve different requesters concurrently.
REQ-006 Read FSM states SHALL be R_IDLE, R_ADDR, R_DATA.
REQ-007 R_IDLE: when any sN_axi_arvalid is high, the FSM SHALL register the grant and move to R_ADDR on the next edge; no handshake occurs in R_IDLE.
REQ-008 If both requesters are valid, the grant SHALL go to the requester not granted last; a single valid requester SHALL always win.
REQ-009 R_ADDR: the FSM SHALL drive m_axi_araddr/arvalid from the granted requester and drive its arready from m_axi_arready; it SHALL go to R_DATA on the handshake.
REQ-010 R_DATA: the FSM SHALL route m_axi_rdata/rlast/rvalid to the granted requester, with m_axi_rready equal to the granted sN_axi_rready.
REQ-011 On rvalid&rready&rlast, the FSM SHALL go to R_IDLE and update the last-grant pointer.
REQ-012 A beat counter (0..BEATS-1) SHALL increment per accepted read beat; rlast with count != BEATS-1 SHALL pulse rd_len_err, and the burst SHALL still terminate.
REQ-013 Write FSM states SHALL be W_IDLE, W_ADDR, W_DATA, W_RESP, with arbitration identical to REQ-007/008 and its own last-grant pointer.
REQ-014 W_ADDR SHALL forward aw* per REQ-009.
REQ-015 W_DATA SHALL forward wdata/wlast/wvalid/wready per beat; the accepted beat with wlast SHALL move the FSM to W_RESP.
REQ-016 A write beat counter SHALL apply the REQ-012 rule to wr_len_err.
REQ-017 W_RESP SHALL route m_axi_bvalid to the granted requester and set m_axi_bready to its bready; on the handshake the FSM SHALL go to W_IDLE and update the pointer.
REQ-018 The non-granted requester SHALL see arready/awready/wready/rvalid/bvalid = 0 at all times.
REQ-019 A grant SHALL be held until its burst completes, even if the requester drops valid (protocol violation; no re-arbitration).
REQ-020 Requests arriving mid-burst SHALL wait; arbitration SHALL occur only in the IDLE states.

Reset
REQ-021 On reset, both FSMs SHALL go to IDLE, beat counters to 0, and both last-grant pointers to 1, so that s0 wins the first tie.
REQ-022 During and after reset, all outputs SHALL be 0 (data buses 0).
REQ-023 Reset mid-burst SHALL abandon the burst without completing it.

Structure
REQ-024 Package axi_arb_pkg SHALL hold the read/write state enums and the BEATS default.
REQ-025 Sub-module rr_arb2 (two-request round-robin pick with registered pointer) SHALL be instanced once per path.

Verification
REQ-026 s0 read to 0x1000 alone -> m_axi_arvalid rises 1 cycle later with araddr 0x1000; 8 beats reach s0 only; R_IDLE after rlast.
REQ-027 s0 and s1 arvalid in the same cycle after reset -> s0 served first, then s1; a repeated tie -> s1 then s0 (alternating).
REQ-028 s0 read concurrent with s1 write (awaddr 0x2000, 8 beats, then B) -> both complete, no cross-routing, no stalls between paths.
REQ-029 Memory asserts rlast on beat 6 -> rd_len_err pulses 1 cycle; FSM returns to R_IDLE; next request served normally.
REQ-030 Reset asserted in W_DATA at beat 3 -> next cycle all outputs 0, FSMs IDLE; a new s1 write completes afterward.

Source files
------------

// File: rtl/axi_arb_pkg.sv
// Shared types for the two-requester AXI memory arbiter: path FSM states and burst size.
package axi_arb_pkg;

  localparam int BEATS_DEF = 8;

  typedef enum logic [1:0] {
    R_IDLE,
    R_ADDR,
    R_DATA
  } rd_state_e;

  typedef enum logic [1:0] {
    W_IDLE,
    W_ADDR,
    W_DATA,
    W_RESP
  } wr_state_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-request round-robin pick; combinational pick, registered last-grant pointer.
// Pointer only moves when the owning path reports a finished burst via upd_vld.
module rr_arb2 (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req_vld,
  input  logic       upd_vld,
  input  logic       upd_idx,
  output logic       pick
);

  logic last_q, last_d;

  always_comb begin
    last_d = last_q;
    if (upd_vld) last_d = upd_idx;

    pick = 1'b0;
    case (req_vld)
      2'b10:   pick = 1'b1;
      2'b11:   pick = ~last_q;
      default: pick = 1'b0;
    endcase
  end

  // Reset pointer says "s1 went last" so s0 takes the first tie.
  always_ff @(posedge clk) begin
    if (reset) last_q <= 1'b1;
    else       last_q <= last_d;
  end

endmodule

// File: rtl/axi_mem_arbiter.sv
// Two-requester AXI read/write arbiter onto one memory port; independent read and write FSMs.
// Grant registers one cycle after a request; beats/handshakes pass combinationally, backpressure routed to the granted side only.
module axi_mem_arbiter
  import axi_arb_pkg::*;
#(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64,
  parameter int BEATS  = BEATS_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] s0_axi_araddr,
  input  logic              s0_axi_arvalid,
  output logic              s0_axi_arready,
  output logic [DATA_W-1:0] s0_axi_rdata,
  output logic              s0_axi_rlast,
  output logic              s0_axi_rvalid,
  input  logic              s0_axi_rready,
  input  logic [ADDR_W-1:0] s0_axi_awaddr,
  input  logic              s0_axi_awvalid,
  output logic              s0_axi_awready,
  input  logic [DATA_W-1:0] s0_axi_wdata,
  input  logic              s0_axi_wlast,
  input  logic              s0_axi_wvalid,
  output logic              s0_axi_wready,
  output logic              s0_axi_bvalid,
  input  logic              s0_axi_bready,
  input  logic [ADDR_W-1:0] s1_axi_araddr,
  input  logic              s1_axi_arvalid,
  output logic              s1_axi_arready,
  output logic [DATA_W-1:0] s1_axi_rdata,
  output logic              s1_axi_rlast,
  output logic              s1_axi_rvalid,
  input  logic              s1_axi_rready,
  input  logic [ADDR_W-1:0] s1_axi_awaddr,
  input  logic              s1_axi_awvalid,
  output logic              s1_axi_awready,
  input  logic [DATA_W-1:0] s1_axi_wdata,
  input  logic              s1_axi_wlast,
  input  logic              s1_axi_wvalid,
  output logic              s1_axi_wready,
  output logic              s1_axi_bvalid,
  input  logic              s1_axi_bready,
  output logic [ADDR_W-1:0] m_axi_araddr,
  output logic              m_axi_arvalid,
  input  logic              m_axi_arready,
  input  logic [DATA_W-1:0] m_axi_rdata,
  input  logic              m_axi_rlast,
  input  logic              m_axi_rvalid,
  output logic              m_axi_rready,
  output logic [ADDR_W-1:0] m_axi_awaddr,
  output logic              m_axi_awvalid,
  input  logic              m_axi_awready,
  output logic [DATA_W-1:0] m_axi_wdata,
  output logic              m_axi_wlast,
  output logic              m_axi_wvalid,
  input  logic              m_axi_wready,
  input  logic              m_axi_bvalid,
  output logic              m_axi_bready,
  output logic              rd_len_err,
  output logic              wr_len_err
);

  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

  rd_state_e        r_state_q, r_state_d;
  logic             r_gnt_q, r_gnt_d;
  logic [CNT_W-1:0] r_cnt_q, r_cnt_d;
  logic             rd_len_err_q, rd_len_err_d;
  logic             r_pick, r_done;

  wr_state_e        w_state_q, w_state_d;
  logic             w_gnt_q, w_gnt_d;
  logic [CNT_W-1:0] w_cnt_q, w_cnt_d;
  logic             wr_len_err_q, wr_len_err_d;
  logic             w_pick, w_done;

  rr_arb2 u_rd_arb (
    .clk     (clk),
    .reset   (reset),
    .req_vld ({s1_axi_arvalid, s0_axi_arvalid}),
    .upd_vld (r_done),
    .upd_idx (r_gnt_q),
    .pick    (r_pick)
  );

  rr_arb2 u_wr_arb (
    .clk     (clk),
    .reset   (reset),
    .req_vld ({s1_axi_awvalid, s0_axi_awvalid}),
    .upd_vld (w_done),
    .upd_idx (w_gnt_q),
    .pick    (w_pick)
  );

  // Whole case is skipped under reset so every output reads 0 while reset is high.
  always_comb begin
    r_state_d      = r_state_q;
    r_gnt_d        = r_gnt_q;
    r_cnt_d        = r_cnt_q;
    rd_len_err_d   = 1'b0;
    r_done         = 1'b0;
    m_axi_araddr   = '0;
    m_axi_arvalid  = 1'b0;
    m_axi_rready   = 1'b0;
    s0_axi_arready = 1'b0;
    s1_axi_arready = 1'b0;
    s0_axi_rdata   = '0;
    s0_axi_rlast   = 1'b0;
    s0_axi_rvalid  = 1'b0;
    s1_axi_rdata   = '0;
    s1_axi_rlast   = 1'b0;
    s1_axi_rvalid  = 1'b0;
    if (!reset) begin
      case (r_state_q)
        R_IDLE: begin
          if (s0_axi_arvalid || s1_axi_arvalid) begin
            r_gnt_d   = r_pick;
            r_state_d = R_ADDR;
          end
        end
        R_ADDR: begin
          m_axi_araddr  = r_gnt_q ? s1_axi_araddr : s0_axi_araddr;
          m_axi_arvalid = r_gnt_q ? s1_axi_arvalid : s0_axi_arvalid;
          if (r_gnt_q) s1_axi_arready = m_axi_arready;
          else         s0_axi_arready = m_axi_arready;
          if ((r_gnt_q ? s1_axi_arvalid : s0_axi_arvalid) && m_axi_arready) begin
            r_cnt_d   = '0;
            r_state_d = R_DATA;
          end
        end
        R_DATA: begin
          m_axi_rready = r_gnt_q ? s1_axi_rready : s0_axi_rready;
          if (r_gnt_q) begin
            s1_axi_rdata  = m_axi_rdata;
            s1_axi_rlast  = m_axi_rlast;
            s1_axi_rvalid = m_axi_rvalid;
          end else begin
            s0_axi_rdata  = m_axi_rdata;
            s0_axi_rlast  = m_axi_rlast;
            s0_axi_rvalid = m_axi_rvalid;
          end
          if (m_axi_rvalid && (r_gnt_q ? s1_axi_rready : s0_axi_rready)) begin
            r_cnt_d = r_cnt_q + 1'b1;
            if (m_axi_rlast) begin
              rd_len_err_d = (r_cnt_q != LAST_BEAT);
              r_done       = 1'b1;
              r_state_d    = R_IDLE;
            end
          end
        end
        default: r_state_d = R_IDLE;
      endcase
    end
  end

  always_comb begin
    w_state_d      = w_state_q;
    w_gnt_d        = w_gnt_q;
    w_cnt_d        = w_cnt_q;
    wr_len_err_d   = 1'b0;
    w_done         = 1'b0;
    m_axi_awaddr   = '0;
    m_axi_awvalid  = 1'b0;
    m_axi_wdata    = '0;
    m_axi_wlast    = 1'b0;
    m_axi_wvalid   = 1'b0;
    m_axi_bready   = 1'b0;
    s0_axi_awready = 1'b0;
    s1_axi_awready = 1'b0;
    s0_axi_wready  = 1'b0;
    s1_axi_wready  = 1'b0;
    s0_axi_bvalid  = 1'b0;
    s1_axi_bvalid  = 1'b0;
    if (!reset) begin
      case (w_state_q)
        W_IDLE: begin
          if (s0_axi_awvalid || s1_axi_awvalid) begin
            w_gnt_d   = w_pick;
            w_state_d = W_ADDR;
          end
        end
        W_ADDR: begin
          m_axi_awaddr  = w_gnt_q ? s1_axi_awaddr : s0_axi_awaddr;
          m_axi_awvalid = w_gnt_q ? s1_axi_awvalid : s0_axi_awvalid;
          if (w_gnt_q) s1_axi_awready = m_axi_awready;
          else         s0_axi_awready = m_axi_awready;
          if ((w_gnt_q ? s1_axi_awvalid : s0_axi_awvalid) && m_axi_awready) begin
            w_cnt_d   = '0;
            w_state_d = W_DATA;
          end
        end
        W_DATA: begin
          m_axi_wdata  = w_gnt_q ? s1_axi_wdata : s0_axi_wdata;
          m_axi_wlast  = w_gnt_q ? s1_axi_wlast : s0_axi_wlast;
          m_axi_wvalid = w_gnt_q ? s1_axi_wvalid : s0_axi_wvalid;
          if (w_gnt_q) s1_axi_wready = m_axi_wready;
          else         s0_axi_wready = m_axi_wready;
          if ((w_gnt_q ? s1_axi_wvalid : s0_axi_wvalid) && m_axi_wready) begin
            w_cnt_d = w_cnt_q + 1'b1;
            if (w_gnt_q ? s1_axi_wlast : s0_axi_wlast) begin
              wr_len_err_d = (w_cnt_q != LAST_BEAT);
              w_state_d    = W_RESP;
            end
          end
        end
        W_RESP: begin
          m_axi_bready = w_gnt_q ? s1_axi_bready : s0_axi_bready;
          if (w_gnt_q) s1_axi_bvalid = m_axi_bvalid;
          else         s0_axi_bvalid = m_axi_bvalid;
          if (m_axi_bvalid && (w_gnt_q ? s1_axi_bready : s0_axi_bready)) begin
            w_done    = 1'b1;
            w_state_d = W_IDLE;
          end
        end
        default: w_state_d = W_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state_q    <= R_IDLE;
      r_gnt_q      <= 1'b0;
      r_cnt_q      <= '0;
      rd_len_err_q <= 1'b0;
      w_state_q    <= W_IDLE;
      w_gnt_q      <= 1'b0;
      w_cnt_q      <= '0;
      wr_len_err_q <= 1'b0;
    end else begin
      r_state_q    <= r_state_d;
      r_gnt_q      <= r_gnt_d;
      r_cnt_q      <= r_cnt_d;
      rd_len_err_q <= rd_len_err_d;
      w_state_q    <= w_state_d;
      w_gnt_q      <= w_gnt_d;
      w_cnt_q      <= w_cnt_d;
      wr_len_err_q <= wr_len_err_d;
    end
  end

  assign rd_len_err = rd_len_err_q & ~reset;
  assign wr_len_err = wr_len_err_q & ~reset;

endmodule

// File: tb/tb_axi_mem_arbiter.sv
// Directed bench for axi_mem_arbiter: a scripted memory side and requesters with hand-computed expectations.
module tb_axi_mem_arbiter;

  logic        clk;
  logic        reset;
  logic [63:0] s0_axi_araddr, s1_axi_araddr, s0_axi_awaddr, s1_axi_awaddr;
  logic        s0_axi_arvalid, s1_axi_arvalid, s0_axi_arready, s1_axi_arready;
  logic [63:0] s0_axi_rdata, s1_axi_rdata;
  logic        s0_axi_rlast, s1_axi_rlast, s0_axi_rvalid, s1_axi_rvalid;
  logic        s0_axi_rready, s1_axi_rready;
  logic        s0_axi_awvalid, s1_axi_awvalid, s0_axi_awready, s1_axi_awready;
  logic [63:0] s0_axi_wdata, s1_axi_wdata;
  logic        s0_axi_wlast, s1_axi_wlast, s0_axi_wvalid, s1_axi_wvalid;
  logic        s0_axi_wready, s1_axi_wready;
  logic        s0_axi_bvalid, s1_axi_bvalid, s0_axi_bready, s1_axi_bready;
  logic [63:0] m_axi_araddr, m_axi_awaddr, m_axi_rdata, m_axi_wdata;
  logic        m_axi_arvalid, m_axi_arready, m_axi_rlast, m_axi_rvalid, m_axi_rready;
  logic        m_axi_awvalid, m_axi_awready, m_axi_wlast, m_axi_wvalid, m_axi_wready;
  logic        m_axi_bvalid, m_axi_bready;
  logic        rd_len_err, wr_len_err;

  int tests_run    = 0;
  int tests_failed = 0;
  int cyc          = 0;
  int c0;

  axi_mem_arbiter dut (
    .clk            (clk),
    .reset          (reset),
    .s0_axi_araddr  (s0_axi_araddr),
    .s0_axi_arvalid (s0_axi_arvalid),
    .s0_axi_arready (s0_axi_arready),
    .s0_axi_rdata   (s0_axi_rdata),
    .s0_axi_rlast   (s0_axi_rlast),
    .s0_axi_rvalid  (s0_axi_rvalid),
    .s0_axi_rready  (s0_axi_rready),
    .s0_axi_awaddr  (s0_axi_awaddr),
    .s0_axi_awvalid (s0_axi_awvalid),
    .s0_axi_awready (s0_axi_awready),
    .s0_axi_wdata   (s0_axi_wdata),
    .s0_axi_wlast   (s0_axi_wlast),
    .s0_axi_wvalid  (s0_axi_wvalid),
    .s0_axi_wready  (s0_axi_wready),
    .s0_axi_bvalid  (s0_axi_bvalid),
    .s0_axi_bready  (s0_axi_bready),
    .s1_axi_araddr  (s1_axi_araddr),
    .s1_axi_arvalid (s1_axi_arvalid),
    .s1_axi_arready (s1_axi_arready),
    .s1_axi_rdata   (s1_axi_rdata),
    .s1_axi_rlast   (s1_axi_rlast),
    .s1_axi_rvalid  (s1_axi_rvalid),
    .s1_axi_rready  (s1_axi_rready),
    .s1_axi_awaddr  (s1_axi_awaddr),
    .s1_axi_awvalid (s1_axi_awvalid),
    .s1_axi_awready (s1_axi_awready),
    .s1_axi_wdata   (s1_axi_wdata),
    .s1_axi_wlast   (s1_axi_wlast),
    .s1_axi_wvalid  (s1_axi_wvalid),
    .s1_axi_wready  (s1_axi_wready),
    .s1_axi_bvalid  (s1_axi_bvalid),
    .s1_axi_bready  (s1_axi_bready),
    .m_axi_araddr   (m_axi_araddr),
    .m_axi_arvalid  (m_axi_arvalid),
    .m_axi_arready  (m_axi_arready),
    .m_axi_rdata    (m_axi_rdata),
    .m_axi_rlast    (m_axi_rlast),
    .m_axi_rvalid   (m_axi_rvalid),
    .m_axi_rready   (m_axi_rready),
    .m_axi_awaddr   (m_axi_awaddr),
    .m_axi_awvalid  (m_axi_awvalid),
    .m_axi_awready  (m_axi_awready),
    .m_axi_wdata    (m_axi_wdata),
    .m_axi_wlast    (m_axi_wlast),
    .m_axi_wvalid   (m_axi_wvalid),
    .m_axi_wready   (m_axi_wready),
    .m_axi_bvalid   (m_axi_bvalid),
    .m_axi_bready   (m_axi_bready),
    .rd_len_err     (rd_len_err),
    .wr_len_err     (wr_len_err)
  );

  logic any_out;
  assign any_out = |{s0_axi_arready, s0_axi_rdata, s0_axi_rlast, s0_axi_rvalid, s0_axi_awready,
                     s0_axi_wready, s0_axi_bvalid, s1_axi_arready, s1_axi_rdata, s1_axi_rlast,
                     s1_axi_rvalid, s1_axi_awready, s1_axi_wready, s1_axi_bvalid,
                     m_axi_araddr, m_axi_arvalid, m_axi_rready, m_axi_awaddr, m_axi_awvalid,
                     m_axi_wdata, m_axi_wlast, m_axi_wvalid, m_axi_bready, rd_len_err, wr_len_err};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Entered at a cycle where the read FSM is idle and the caller already drives arvalid.
  task automatic rd_burst(input logic g, input logic [63:0] addr, input int n,
                          input logic drop, input logic exp_err);
    #1;
    check_eq("rd_idle_no_arvalid", 64'(m_axi_arvalid), 64'd0);
    @(posedge clk); #1;
    m_axi_arready = 1'b1;
    #1;
    check_eq("rd_araddr", m_axi_araddr, addr);
    check_eq("rd_arready_gnt", 64'(g ? s1_axi_arready : s0_axi_arready), 64'd1);
    check_eq("rd_arready_oth", 64'(g ? s0_axi_arready : s1_axi_arready), 64'd0);
    @(posedge clk); #1;
    m_axi_arready = 1'b0;
    if (drop) begin
      if (g) s1_axi_arvalid = 1'b0;
      else   s0_axi_arvalid = 1'b0;
    end
    s0_axi_rready = 1'b1;
    s1_axi_rready = 1'b1;
    for (int i = 0; i < n; i++) begin
      m_axi_rvalid = 1'b1;
      m_axi_rdata  = addr + 64'(i);
      m_axi_rlast  = (i == n - 1);
      #1;
      check_eq("rd_rvalid_gnt", 64'(g ? s1_axi_rvalid : s0_axi_rvalid), 64'd1);
      check_eq("rd_rdata_gnt", g ? s1_axi_rdata : s0_axi_rdata, addr + 64'(i));
      check_eq("rd_rvalid_oth", 64'(g ? s0_axi_rvalid : s1_axi_rvalid), 64'd0);
      @(posedge clk); #1;
    end
    m_axi_rvalid = 1'b0;
    m_axi_rlast  = 1'b0;
    m_axi_rdata  = '0;
    #1;
    check_eq("rd_len_err", 64'(rd_len_err), 64'(exp_err));
    check_eq("rd_back_idle_rready", 64'(m_axi_rready), 64'd0);
  endtask

  task automatic wr_burst(input logic g, input logic [63:0] addr, input int n,
                          input logic drop, input logic exp_err);
    #1;
    check_eq("wr_idle_no_awvalid", 64'(m_axi_awvalid), 64'd0);
    @(posedge clk); #1;
    m_axi_awready = 1'b1;
    #1;
    check_eq("wr_awaddr", m_axi_awaddr, addr);
    check_eq("wr_awready_gnt", 64'(g ? s1_axi_awready : s0_axi_awready), 64'd1);
    check_eq("wr_awready_oth", 64'(g ? s0_axi_awready : s1_axi_awready), 64'd0);
    @(posedge clk); #1;
    m_axi_awready = 1'b0;
    if (drop) begin
      if (g) s1_axi_awvalid = 1'b0;
      else   s0_axi_awvalid = 1'b0;
    end
    m_axi_wready = 1'b1;
    for (int i = 0; i < n; i++) begin
      if (g) begin
        s1_axi_wvalid = 1'b1;
        s1_axi_wdata  = addr + 64'(i);
        s1_axi_wlast  = (i == n - 1);
      end else begin
        s0_axi_wvalid = 1'b1;
        s0_axi_wdata  = addr + 64'(i);
        s0_axi_wlast  = (i == n - 1);
      end
      #1;
      check_eq("wr_wvalid", 64'(m_axi_wvalid), 64'd1);
      check_eq("wr_wdata", m_axi_wdata, addr + 64'(i));
      check_eq("wr_wlast", 64'(m_axi_wlast), 64'(i == n - 1));
      check_eq("wr_wready_gnt", 64'(g ? s1_axi_wready : s0_axi_wready), 64'd1);
      check_eq("wr_wready_oth", 64'(g ? s0_axi_wready : s1_axi_wready), 64'd0);
      @(posedge clk); #1;
    end
    s0_axi_wvalid = 1'b0; s0_axi_wlast = 1'b0; s0_axi_wdata = '0;
    s1_axi_wvalid = 1'b0; s1_axi_wlast = 1'b0; s1_axi_wdata = '0;
    m_axi_wready  = 1'b0;
    m_axi_bvalid  = 1'b1;
    if (g) s1_axi_bready = 1'b1;
    else   s0_axi_bready = 1'b1;
    #1;
    check_eq("wr_len_err", 64'(wr_len_err), 64'(exp_err));
    check_eq("wr_bvalid_gnt", 64'(g ? s1_axi_bvalid : s0_axi_bvalid), 64'd1);
    check_eq("wr_bvalid_oth", 64'(g ? s0_axi_bvalid : s1_axi_bvalid), 64'd0);
    check_eq("wr_bready", 64'(m_axi_bready), 64'd1);
    @(posedge clk); #1;
    m_axi_bvalid  = 1'b0;
    s0_axi_bready = 1'b0;
    s1_axi_bready = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    s0_axi_araddr = '0; s0_axi_arvalid = 1'b0; s0_axi_rready = 1'b0;
    s0_axi_awaddr = '0; s0_axi_awvalid = 1'b0; s0_axi_wdata = '0;
    s0_axi_wlast = 1'b0; s0_axi_wvalid = 1'b0; s0_axi_bready = 1'b0;
    s1_axi_araddr = '0; s1_axi_arvalid = 1'b0; s1_axi_rready = 1'b0;
    s1_axi_awaddr = '0; s1_axi_awvalid = 1'b0; s1_axi_wdata = '0;
    s1_axi_wlast = 1'b0; s1_axi_wvalid = 1'b0; s1_axi_bready = 1'b0;
    m_axi_arready = 1'b0; m_axi_rdata = '0; m_axi_rlast = 1'b0; m_axi_rvalid = 1'b0;
    m_axi_awready = 1'b0; m_axi_wready = 1'b0; m_axi_bvalid = 1'b0;

    // Outputs stay 0 under reset even with live inputs.
    repeat (3) @(posedge clk);
    #1;
    s0_axi_arvalid = 1'b1; s0_axi_rready = 1'b1; m_axi_rvalid = 1'b1;
    m_axi_rdata = 64'hDEAD; m_axi_bvalid = 1'b1; s1_axi_wvalid = 1'b1; m_axi_wready = 1'b1;
    #1;
    check_eq("reset_outs_zero", 64'(any_out), 64'd0);
    s0_axi_arvalid = 1'b0; s0_axi_rready = 1'b0; m_axi_rvalid = 1'b0;
    m_axi_rdata = '0; m_axi_bvalid = 1'b0; s1_axi_wvalid = 1'b0; m_axi_wready = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    check_eq("post_reset_outs_zero", 64'(any_out), 64'd0);

    // Tie right after reset: s0, then s1 (tie again while s0 still asks), then s0.
    s0_axi_araddr = 64'hA000; s1_axi_araddr = 64'hB000;
    s0_axi_arvalid = 1'b1; s1_axi_arvalid = 1'b1;
    rd_burst(1'b0, 64'hA000, 8, 1'b0, 1'b0);
    rd_burst(1'b1, 64'hB000, 8, 1'b1, 1'b0);
    rd_burst(1'b0, 64'hA000, 8, 1'b1, 1'b0);

    @(posedge clk); #1;
    s0_axi_araddr = 64'h1000; s0_axi_arvalid = 1'b1;
    rd_burst(1'b0, 64'h1000, 8, 1'b1, 1'b0);

    // Concurrent s0 read and s1 write: write path takes 11 edges, read 10.
    @(posedge clk); #1;
    s0_axi_araddr = 64'h1000; s0_axi_arvalid = 1'b1;
    s1_axi_awaddr = 64'h2000; s1_axi_awvalid = 1'b1;
    c0 = cyc;
    fork
      rd_burst(1'b0, 64'h1000, 8, 1'b1, 1'b0);
      wr_burst(1'b1, 64'h2000, 8, 1'b1, 1'b0);
    join
    check_eq("concurrent_cycles", 64'(cyc - c0), 64'd11);

    // Short read burst flags once, then a normal burst runs clean.
    @(posedge clk); #1;
    s0_axi_araddr = 64'h4000; s0_axi_arvalid = 1'b1;
    rd_burst(1'b0, 64'h4000, 7, 1'b1, 1'b1);
    @(posedge clk); #1;
    check_eq("rd_len_err_one_cycle", 64'(rd_len_err), 64'd0);
    s1_axi_araddr = 64'h5000; s1_axi_arvalid = 1'b1;
    rd_burst(1'b1, 64'h5000, 8, 1'b1, 1'b0);

    // Write tie (pointer last at s1) goes to s0 first; then a short write burst.
    @(posedge clk); #1;
    s0_axi_awaddr = 64'h6000; s1_axi_awaddr = 64'h7000;
    s0_axi_awvalid = 1'b1; s1_axi_awvalid = 1'b1;
    wr_burst(1'b0, 64'h6000, 8, 1'b1, 1'b0);
    wr_burst(1'b1, 64'h7000, 8, 1'b1, 1'b0);
    @(posedge clk); #1;
    s0_axi_awaddr = 64'h8000; s0_axi_awvalid = 1'b1;
    wr_burst(1'b0, 64'h8000, 5, 1'b1, 1'b1);
    @(posedge clk); #1;
    check_eq("wr_len_err_one_cycle", 64'(wr_len_err), 64'd0);

    // Reset in the middle of a write data phase, on beat 3.
    s1_axi_awaddr = 64'h9000; s1_axi_awvalid = 1'b1;
    @(posedge clk); #1;
    m_axi_awready = 1'b1;
    @(posedge clk); #1;
    m_axi_awready = 1'b0; s1_axi_awvalid = 1'b0; m_axi_wready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      s1_axi_wvalid = 1'b1;
      s1_axi_wdata  = 64'h9000 + 64'(i);
      s1_axi_wlast  = 1'b0;
      if (i < 3) begin
        @(posedge clk); #1;
      end
    end
    #1;
    check_eq("mid_wr_beat3_wvalid", 64'(m_axi_wvalid), 64'd1);
    reset = 1'b1;
    #1;
    check_eq("mid_wr_reset_outs", 64'(any_out), 64'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    check_eq("after_mid_reset_outs", 64'(any_out), 64'd0);
    s1_axi_wvalid = 1'b0; s1_axi_wdata = '0; m_axi_wready = 1'b0;
    @(posedge clk); #1;
    s1_axi_awaddr = 64'hC000; s1_axi_awvalid = 1'b1;
    wr_burst(1'b1, 64'hC000, 8, 1'b1, 1'b0);

    @(posedge clk); #1;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
